mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/lsu_align.sv | 93 +++++++++
 rtl/mem_stage_ctrl.sv | 140 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the MEM-stage load/store path.
// Holds the MEM controller state encoding and the RV32I funct3 codes
// for loads and stores.
package riscv_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the MEM stage.
// Decodes funct3 into legality / misalignment, builds byte enables and
// lane-replicated store data, and extracts/extends load data from a word.
//   funct3     : access size/sign
//   is_store   : 1 = store decode, 0 = load decode
//   addr_lo    : byte offset within the word
//   store_data : right-aligned store data
//   load_word  : captured read word
//   be         : byte enables
//   wdata      : store data replicated into all lanes
//   load_data  : extracted, extended load result
//   legal      : funct3 is a valid op for this direction
//   misaligned : legal op whose offset violates its natural alignment
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        legal,
  output logic        misaligned
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = load_word >> {addr_lo, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr_lo[1] ? load_word[31:16] : load_word[15:0];
  end

  always_comb begin
    be         = 4'b0000;
    wdata      = 32'd0;
    load_data  = 32'd0;
    legal      = 1'b0;
    misaligned = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          legal = 1'b1;
          be    = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        F3_SH: begin
          legal      = 1'b1;
          misaligned = addr_lo[0];
          be         = 4'b0011 << {addr_lo[1], 1'b0};
          wdata      = {2{store_data[15:0]}};
        end
        F3_SW: begin
          legal      = 1'b1;
          misaligned = |addr_lo;
          be         = 4'b1111;
          wdata      = store_data;
        end
        default: ;
      endcase
    end else begin
      case (funct3)
        F3_LB: begin
          legal = 1'b1; be = 4'b1111;
          load_data = {{24{byte_sel[7]}}, byte_sel};
        end
        F3_LBU: begin
          legal = 1'b1; be = 4'b1111;
          load_data = {24'd0, byte_sel};
        end
        F3_LH: begin
          legal = 1'b1; be = 4'b1111; misaligned = addr_lo[0];
          load_data = {{16{half_sel[15]}}, half_sel};
        end
        F3_LHU: begin
          legal = 1'b1; be = 4'b1111; misaligned = addr_lo[0];
          load_data = {16'd0, half_sel};
        end
        F3_LW: begin
          legal = 1'b1; be = 4'b1111; misaligned = |addr_lo;
          load_data = load_word;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage load/store controller.
// Issues one data-memory request per MEM-stage op, stalls the pipeline
// until the memory answers (or a timeout fires), then releases the op
// for one DONE cycle carrying the extended load data.
//   clk, rst            : clock, synchronous active-high reset
//   mem_read_m/_write_m : load / store in MEM (both set = store)
//   funct3_m            : access size/sign
//   alu_result_m        : byte address
//   write_data_m        : right-aligned store data
//   dmem_*              : request/response to data memory
//   read_data_m         : extended load data to MEM/WB
//   mem_stall           : freeze upstream pipeline registers
//   wb_bubble           : MEM/WB loads a bubble
//   misalign_exc        : misaligned-access pulse
//   timeout_exc         : memory-timeout pulse
module mem_stage_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] read_data_m,
  output logic        mem_stall,
  output logic        wb_bubble,
  output logic        misalign_exc,
  output logic        timeout_exc
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  mem_state_t  state, state_nxt;
  logic [7:0]  cnt;
  logic [31:0] cap;
  logic        to_q;

  logic        op, legal, misal, go, busy, to_hit;
  logic [3:0]  be_w;
  logic [31:0] wdata_w, ld_w;
  logic [7:0]  cnt_inc;

  assign op      = mem_read_m | mem_write_m;
  assign go      = op & legal & ~misal;
  assign busy    = (state == MEM_BUSY);
  assign cnt_inc = cnt + 8'd1;
  assign to_hit  = busy & ~dmem_ready & (cnt_inc == TO_LIM);

  // Store wins when both read and write are flagged.
  lsu_align u_align (
    .funct3     (funct3_m),
    .is_store   (mem_write_m),
    .addr_lo    (alu_result_m[1:0]),
    .store_data (write_data_m),
    .load_word  (cap),
    .be         (be_w),
    .wdata      (wdata_w),
    .load_data  (ld_w),
    .legal      (legal),
    .misaligned (misal)
  );

  // Request fields are only presented while a request is outstanding,
  // so the bus reads all-zero whenever nothing is in flight.
  assign dmem_we     = busy & mem_write_m;
  assign dmem_addr   = busy ? {alu_result_m[31:2], 2'b00} : 32'd0;
  assign dmem_wdata  = busy ? wdata_w : 32'd0;
  assign dmem_be     = busy ? be_w : 4'b0000;
  assign timeout_exc = to_q;

  always_comb begin
    state_nxt    = state;
    dmem_req     = 1'b0;
    mem_stall    = 1'b0;
    wb_bubble    = 1'b0;
    misalign_exc = 1'b0;
    read_data_m  = 32'd0;
    case (state)
      MEM_IDLE: begin
        misalign_exc = op & legal & misal;
        if (go) begin
          mem_stall = 1'b1;
          wb_bubble = 1'b1;
          state_nxt = MEM_BUSY;
        end
      end
      MEM_BUSY: begin
        dmem_req  = 1'b1;
        mem_stall = 1'b1;
        wb_bubble = 1'b1;
        if (dmem_ready || to_hit) state_nxt = MEM_DONE;
      end
      MEM_DONE: begin
        // Always return to IDLE: the pipeline advances this cycle, so the
        // op that was just serviced is gone before IDLE samples again.
        if (!mem_write_m) read_data_m = ld_w;
        state_nxt = MEM_IDLE;
      end
      default: state_nxt = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MEM_IDLE;
      cnt   <= 8'd0;
      cap   <= 32'd0;
      to_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      to_q  <= 1'b0;
      if (busy) begin
        if (dmem_ready) begin
          cap <= dmem_rdata;
          cnt <= 8'd0;
        end else if (to_hit) begin
          cap  <= 32'd0;
          cnt  <= 8'd0;
          to_q <= 1'b1;
        end else begin
          cnt <= cnt_inc;
        end
      end else begin
        cnt <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl (TIMEOUT_CYCLES = 4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_mem_stage_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_m, mem_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, write_data_m;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] read_data_m;
  logic        mem_stall, wb_bubble, misalign_exc, timeout_exc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_m   (mem_read_m),
    .mem_write_m  (mem_write_m),
    .funct3_m     (funct3_m),
    .alu_result_m (alu_result_m),
    .write_data_m (write_data_m),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_ready   (dmem_ready),
    .dmem_rdata   (dmem_rdata),
    .read_data_m  (read_data_m),
    .mem_stall    (mem_stall),
    .wb_bubble    (wb_bubble),
    .misalign_exc (misalign_exc),
    .timeout_exc  (timeout_exc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic clear_op;
    mem_read_m = 1'b0; mem_write_m = 1'b0; funct3_m = 3'b000;
    alu_result_m = 32'd0; write_data_m = 32'd0;
  endtask

  // One access, memory ready on the first BUSY cycle.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd);
    tick;
    mem_read_m = rd; mem_write_m = wr; funct3_m = f3;
    alu_result_m = a; write_data_m = wd; dmem_ready = 1'b0; dmem_rdata = 32'd0;
    #1;
    chk1({tag, ".idle_stall"}, mem_stall, 1'b1);
    chk1({tag, ".idle_bubble"}, wb_bubble, 1'b1);
    chk1({tag, ".idle_req"}, dmem_req, 1'b0);
    tick;
    dmem_ready = 1'b1; dmem_rdata = rdata;
    #1;
    chk1({tag, ".busy_req"}, dmem_req, 1'b1);
    chk1({tag, ".busy_stall"}, mem_stall, 1'b1);
    chk1({tag, ".busy_we"}, dmem_we, wr);
    chk({tag, ".busy_addr"}, dmem_addr, {a[31:2], 2'b00});
    chk({tag, ".busy_be"}, {28'd0, dmem_be}, {28'd0, exp_be});
    chk({tag, ".busy_wdata"}, dmem_wdata, exp_wd);
    tick;
    dmem_ready = 1'b0; dmem_rdata = 32'd0;
    #1;
    chk1({tag, ".done_stall"}, mem_stall, 1'b0);
    chk1({tag, ".done_bubble"}, wb_bubble, 1'b0);
    chk1({tag, ".done_req"}, dmem_req, 1'b0);
    chk({tag, ".done_rdata"}, read_data_m, exp_rd);
    tick;
    clear_op;
    #1;
    chk1({tag, ".after_stall"}, mem_stall, 1'b0);
    chk({tag, ".after_rdata"}, read_data_m, 32'd0);
  endtask

  initial begin
    rst = 1'b1; dmem_ready = 1'b0; dmem_rdata = 32'd0;
    clear_op;
    tick; tick;
    rst = 1'b0;
    #1;
    chk1("rst.req", dmem_req, 1'b0);
    chk1("rst.we", dmem_we, 1'b0);
    chk1("rst.stall", mem_stall, 1'b0);
    chk1("rst.bubble", wb_bubble, 1'b0);
    chk1("rst.mis", misalign_exc, 1'b0);
    chk1("rst.to", timeout_exc, 1'b0);
    chk("rst.rdata", read_data_m, 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);

    access("lw",   1, 0, F3_LW,  32'h100, 32'h0, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
    access("lb",   1, 0, F3_LB,  32'h103, 32'h0, 32'h80112233, 4'b1111, 32'h0, 32'hFFFFFF80);
    access("lbu",  1, 0, F3_LBU, 32'h103, 32'h0, 32'h80112233, 4'b1111, 32'h0, 32'h00000080);
    access("lh",   1, 0, F3_LH,  32'h102, 32'h0, 32'h80112233, 4'b1111, 32'h0, 32'hFFFF8011);
    access("lhu",  1, 0, F3_LHU, 32'h100, 32'h0, 32'h80112233, 4'b1111, 32'h0, 32'h00002233);
    access("sh",   0, 1, F3_SH,  32'h102, 32'h0000ABCD, 32'h0, 4'b1100, 32'hABCDABCD, 32'h0);
    access("sb",   0, 1, F3_SB,  32'h101, 32'h0000005A, 32'h0, 4'b0010, 32'h5A5A5A5A, 32'h0);
    access("rdwr", 1, 1, F3_SW,  32'h104, 32'h12345678, 32'h0, 4'b1111, 32'h12345678, 32'h0);

    // Misaligned LW: exception pulse, no request, no stall.
    tick;
    mem_read_m = 1'b1; funct3_m = F3_LW; alu_result_m = 32'h101;
    #1;
    chk1("mis.exc", misalign_exc, 1'b1);
    chk1("mis.stall", mem_stall, 1'b0);
    chk1("mis.req", dmem_req, 1'b0);
    tick;
    clear_op;
    #1;
    chk1("mis.exc_gone", misalign_exc, 1'b0);
    chk1("mis.req_after", dmem_req, 1'b0);
    chk("mis.rdata", read_data_m, 32'd0);

    // Illegal load funct3 and illegal store funct3: silently ignored.
    tick;
    mem_read_m = 1'b1; funct3_m = 3'b011; alu_result_m = 32'h200;
    #1;
    chk1("ill_ld.stall", mem_stall, 1'b0);
    chk1("ill_ld.mis", misalign_exc, 1'b0);
    tick;
    #1;
    chk1("ill_ld.req", dmem_req, 1'b0);
    tick;
    clear_op;
    mem_write_m = 1'b1; funct3_m = 3'b100; alu_result_m = 32'h200;
    #1;
    chk1("ill_st.stall", mem_stall, 1'b0);
    chk1("ill_st.mis", misalign_exc, 1'b0);
    tick;
    #1;
    chk1("ill_st.req", dmem_req, 1'b0);
    chk1("ill_st.we", dmem_we, 1'b0);
    tick;
    clear_op;

    // Timeout: ready never comes, 4 BUSY cycles then DONE with a pulse.
    mem_read_m = 1'b1; funct3_m = F3_LW; alu_result_m = 32'h200;
    #1;
    chk1("to.idle_stall", mem_stall, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick; #1;
      chk1($sformatf("to.busy%0d_req", i), dmem_req, 1'b1);
      chk1($sformatf("to.busy%0d_exc", i), timeout_exc, 1'b0);
    end
    tick; #1;
    chk1("to.exc", timeout_exc, 1'b1);
    chk1("to.req_drop", dmem_req, 1'b0);
    chk1("to.stall", mem_stall, 1'b0);
    chk("to.rdata", read_data_m, 32'd0);
    tick;
    clear_op;
    #1;
    chk1("to.exc_gone", timeout_exc, 1'b0);
    chk1("to.idle_stall2", mem_stall, 1'b0);

    // Reset during the second BUSY cycle abandons the request.
    tick;
    mem_read_m = 1'b1; funct3_m = F3_LW; alu_result_m = 32'h300;
    tick; #1;
    chk1("rstb.busy1_req", dmem_req, 1'b1);
    tick;
    rst = 1'b1;
    #1;
    chk1("rstb.busy2_req", dmem_req, 1'b1);
    tick;
    rst = 1'b0;
    clear_op;
    #1;
    chk1("rstb.req", dmem_req, 1'b0);
    chk1("rstb.stall", mem_stall, 1'b0);
    chk1("rstb.to", timeout_exc, 1'b0);
    chk("rstb.rdata", read_data_m, 32'd0);

    // Controller still works after the abandoned request.
    access("lw2", 1, 0, F3_LW, 32'h108, 32'h0, 32'h0BADF00D, 4'b1111, 32'h0, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
